// File: rtl/cmd_parser.sv
// cmd_parser: frames the AVR receive byte stream into checked uplink commands.
// Frame: SYNC, ID, LEN, LEN payload bytes, CHK where CHK = ID ^ LEN ^ payload.
// Good frames give a one-cycle cmd_valid; cmd_* hold until the next good frame.
// Ports: clk, rst_n (sync, active-low); rx_data/new_rx_data byte input;
//   cmd_valid/cmd_id/cmd_len/cmd_payload command output; err_chk/err_len/
//   err_timeout one-cycle error pulses; frame_cnt (wraps), err_cnt (saturates).
// Optional macro CMD_PARSER_ACK_EN adds tx_data/new_tx_data/tx_busy and sends
//   a two-byte ACK (06,id) or NAK (15,id) after each good or bad-checksum frame.
module cmd_parser #(
  parameter int          MAX_LEN = 8,
  parameter int          TIMEOUT = 500000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 new_rx_data,
`ifdef CMD_PARSER_ACK_EN
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
`endif
  output logic                 cmd_valid,
  output logic [7:0]           cmd_id,
  output logic [3:0]           cmd_len,
  output logic [MAX_LEN*8-1:0] cmd_payload,
  output logic                 err_chk,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic [7:0]           frame_cnt,
  output logic [7:0]           err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_HUNT, S_ID, S_LEN, S_DATA, S_CHK} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tmo_cnt;
  logic [7:0]           id_q;
  logic [3:0]           len_q;
  logic [3:0]           idx;
  logic [7:0]           xor_q;
  logic [MAX_LEN*8-1:0] shadow;

  logic good, bad_chk, bad_len, tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_nxt;
  end

  // A byte strobe always takes priority over timer expiry.
  always_comb begin
    state_nxt = state;
    good      = 1'b0;
    bad_chk   = 1'b0;
    bad_len   = 1'b0;
    tmo       = 1'b0;
    if (new_rx_data) begin
      case (state)
        S_HUNT: if (rx_data == SYNC) state_nxt = S_ID;
        S_ID:   state_nxt = S_LEN;
        S_LEN: begin
          if (rx_data > 8'(MAX_LEN)) begin
            bad_len   = 1'b1;
            state_nxt = S_HUNT;
          end else if (rx_data == 8'd0) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_DATA;
          end
        end
        S_DATA: if (idx == len_q - 4'd1) state_nxt = S_CHK;
        S_CHK: begin
          if (rx_data == xor_q) good    = 1'b1;
          else                  bad_chk = 1'b1;
          state_nxt = S_HUNT;
        end
        default: state_nxt = S_HUNT;
      endcase
    end else if (state != S_HUNT && tmo_cnt == TW'(TIMEOUT - 1)) begin
      tmo       = 1'b1;
      state_nxt = S_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      id_q        <= '0;
      len_q       <= '0;
      idx         <= '0;
      xor_q       <= '0;
      shadow      <= '0;
      cmd_valid   <= 1'b0;
      cmd_id      <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      cmd_valid   <= good;
      err_chk     <= bad_chk;
      err_len     <= bad_len;
      err_timeout <= tmo;

      if (new_rx_data || state == S_HUNT || tmo) tmo_cnt <= '0;
      else                                       tmo_cnt <= tmo_cnt + TW'(1);

      if ((bad_chk || bad_len || tmo) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;

      if (good) begin
        frame_cnt   <= frame_cnt + 8'd1;
        cmd_id      <= id_q;
        cmd_len     <= len_q;
        cmd_payload <= shadow;
      end

      if (new_rx_data) begin
        case (state)
          S_ID: begin
            id_q  <= rx_data;
            xor_q <= rx_data;
          end
          S_LEN: begin
            len_q  <= rx_data[3:0];
            xor_q  <= xor_q ^ rx_data;
            idx    <= '0;
            // Cleared per frame so bytes beyond LEN read back as zero.
            shadow <= '0;
          end
          S_DATA: begin
            for (int i = 0; i < MAX_LEN; i++)
              if (idx == 4'(i)) shadow[8*i +: 8] <= rx_data;
            xor_q <= xor_q ^ rx_data;
            idx   <= idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CMD_PARSER_ACK_EN
  // Single response slot: requests arriving while busy are dropped.
  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_PULSE, T_GAP} tx_state_t;

  tx_state_t  tx_state, tx_state_nxt;
  logic [7:0] tx_b0, tx_b1;
  logic       tx_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= T_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      T_IDLE:  if (good || bad_chk) tx_state_nxt = T_WAIT;
      T_WAIT:  if (!tx_busy) tx_state_nxt = T_PULSE;
      T_PULSE: tx_state_nxt = T_GAP;
      T_GAP:   tx_state_nxt = tx_sel ? T_IDLE : T_WAIT;
      default: tx_state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_b0       <= '0;
      tx_b1       <= '0;
      tx_sel      <= 1'b0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= (tx_state == T_WAIT) && !tx_busy;
      if (tx_state == T_IDLE && (good || bad_chk)) begin
        tx_b0  <= good ? 8'h06 : 8'h15;
        tx_b1  <= id_q;
        tx_sel <= 1'b0;
      end
      if (tx_state == T_WAIT && !tx_busy) tx_data <= tx_sel ? tx_b1 : tx_b0;
      if (tx_state == T_GAP) tx_sel <= ~tx_sel;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_parser.sv
// Testbench for cmd_parser: directed frames plus randomized frames checked by a
// frame-level reference model through a scoreboard queue and a passive monitor.
module tb_cmd_parser;
  localparam int         ML   = 8;
  localparam int         T    = 40;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [3:0] K_GOOD = 4'b1000, K_CHK = 4'b0100, K_LEN = 4'b0010, K_TMO = 4'b0001;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = 8'd0;
  logic            new_rx_data = 1'b0;
  logic            cmd_valid, err_chk, err_len, err_timeout;
  logic [7:0]      cmd_id, frame_cnt, err_cnt;
  logic [3:0]      cmd_len;
  logic [ML*8-1:0] cmd_payload;
`ifdef CMD_PARSER_ACK_EN
  logic            tx_busy = 1'b0;
  logic [7:0]      tx_data;
  logic            new_tx_data;
`endif

  cmd_parser #(.MAX_LEN(ML), .TIMEOUT(T), .SYNC(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
`ifdef CMD_PARSER_ACK_EN
    .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data),
`endif
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_payload(cmd_payload),
    .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  kind;
    int          at;
    logic [7:0]  id;
    logic [3:0]  len;
    logic [63:0] pay;
    logic [7:0]  fc;
    logic [7:0]  ec;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int last_set = 0;

  // Reference model state: what the outputs must hold after each event.
  logic [7:0]  m_id = 0, m_fc = 0, m_ec = 0;
  logic [3:0]  m_len = 0;
  logic [63:0] m_pay = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input logic [3:0] kind, input int at);
    exp_t e;
    e.kind = kind; e.at = at; e.id = m_id; e.len = m_len;
    e.pay = m_pay; e.fc = m_fc; e.ec = m_ec;
    q.push_back(e);
  endtask

  task automatic push_good(input logic [7:0] id, input int len, input logic [63:0] pay);
    m_id = id; m_len = 4'(len); m_pay = pay; m_fc = m_fc + 8'd1;
    push_ev(K_GOOD, last_set + 1);
  endtask

  task automatic push_err(input logic [3:0] kind, input int at);
    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    push_ev(kind, at);
  endtask

  // Called at posedge+1; presents one byte for exactly one cycle.
  task automatic put(input logic [7:0] b);
    rx_data = b; new_rx_data = 1'b1; last_set = cyc;
    @(posedge clk); #1;
    new_rx_data = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rgap();
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  // mode 0: correct checksum, 1: corrupted checksum, 2: stop after k bytes past SYNC.
  task automatic send_frame(input logic [7:0] id, input logic [7:0] len, input int mode, input int k);
    logic [7:0]  x, b;
    logic [63:0] pay;
    int          sent;
    put(SYNC); rgap();
    if (mode == 2 && k == 0) begin push_err(K_TMO, last_set + 1 + T); idle(T + 3); return; end
    put(id); rgap();
    if (mode == 2 && k == 1) begin push_err(K_TMO, last_set + 1 + T); idle(T + 3); return; end
    put(len);
    if (len > 8'(ML)) begin push_err(K_LEN, last_set + 1); return; end
    rgap();
    sent = 2;
    x = id ^ len; pay = '0;
    for (int i = 0; i < int'(len); i++) begin
      if (mode == 2 && sent == k) begin push_err(K_TMO, last_set + 1 + T); idle(T + 3); return; end
      b = ($urandom_range(0, 9) == 0) ? SYNC : 8'($urandom_range(0, 255));
      pay[8*i +: 8] = b;
      x = x ^ b;
      put(b); rgap();
      sent++;
    end
    if (mode == 2) begin push_err(K_TMO, last_set + 1 + T); idle(T + 3); return; end
    if (mode == 1) begin
      put(x ^ 8'($urandom_range(1, 255)));
      push_err(K_CHK, last_set + 1);
    end else begin
      put(x);
      push_good(id, int'(len), pay);
    end
  endtask

  // Monitor: flags missed events, then compares every presented pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() > 0 && q[0].at < cyc) begin
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL missed_event: kind %b expected at cycle %0d, none by %0d", e.kind, e.at, cyc);
    end
    if (rst_n && (cmd_valid || err_chk || err_len || err_timeout)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d expected none",
                 {cmd_valid, err_chk, err_len, err_timeout}, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {60'd0, cmd_valid, err_chk, err_len, err_timeout}, {60'd0, e.kind});
        check("pulse_cycle", cyc, e.at);
        check("cmd_id", cmd_id, e.id);
        check("cmd_len", cmd_len, e.len);
        check("cmd_payload", cmd_payload, e.pay);
        check("frame_cnt", frame_cnt, e.fc);
        check("err_cnt", err_cnt, e.ec);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_errs", {err_chk, err_len, err_timeout}, 0);
    check("rst_cmd_id", cmd_id, 0);
    check("rst_cmd_len", cmd_len, 0);
    check("rst_payload", cmd_payload, 0);
    check("rst_counts", {frame_cnt, err_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Good frame, bad checksum, then good again.
    put(SYNC); put(8'h01); put(8'h02); put(8'h11); put(8'h22); put(8'h30);
    push_good(8'h01, 2, 64'h2211);
    idle(2);
    put(SYNC); put(8'h01); put(8'h02); put(8'h11); put(8'h22); put(8'h31);
    push_err(K_CHK, last_set + 1);
    idle(2);
    put(SYNC); put(8'h01); put(8'h02); put(8'h11); put(8'h22); put(8'h30);
    push_good(8'h01, 2, 64'h2211);
    // Zero length, then oversize length, then SYNC values as payload.
    put(SYNC); put(8'h07); put(8'h00); put(8'h07);
    push_good(8'h07, 0, 64'h0);
    put(SYNC); put(8'h07); put(8'h09);
    push_err(K_LEN, last_set + 1);
    put(SYNC); put(8'h03); put(8'h02); put(SYNC); put(SYNC); put(8'h01);
    push_good(8'h03, 2, 64'hA5A5);
    // Timeout after SYNC ID.
    put(SYNC); put(8'h01);
    push_err(K_TMO, last_set + 1 + T);
    idle(T + 3);
    // Bytes landing exactly on the expiry cycle keep the frame alive.
    put(SYNC); put(8'h01); idle(T - 1); put(8'h00); idle(T - 1); put(8'h01);
    push_good(8'h01, 0, 64'h0);
    idle(3);

    // Reset mid-frame: no pulses, counters and outputs back to zero.
    put(SYNC); put(8'h01); put(8'h02); put(8'h11);
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    m_id = 0; m_len = 0; m_pay = 0; m_fc = 0; m_ec = 0;
    @(negedge clk);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    put(8'h22); put(8'h30);
    idle(T + 3);
    put(SYNC); put(8'h01); put(8'h02); put(8'h11); put(8'h22); put(8'h30);
    push_good(8'h01, 2, 64'h2211);
    idle(2);

    // Randomized frames with inter-frame garbage.
    for (int n = 0; n < 150; n++) begin
      int sel;
      logic [7:0] g, id;
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == SYNC) g = 8'h00;
        put(g); rgap();
      end
      id  = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      if (sel <= 4)      send_frame(id, 8'($urandom_range(1, ML)), 0, 0);
      else if (sel == 5) send_frame(id, 8'd0, 0, 0);
      else if (sel == 6) send_frame(id, 8'($urandom_range(0, ML)), 1, 0);
      else if (sel == 7) send_frame(id, 8'($urandom_range(ML + 1, 255)), 0, 0);
      else begin
        int l = $urandom_range(0, ML);
        send_frame(id, 8'(l), 2, $urandom_range(0, l + 1));
      end
      rgap();
    end

    // Drive err_cnt into saturation and frame_cnt through its wrap.
    for (int n = 0; n < 260; n++) begin
      put(SYNC); put(8'h44); put(8'hFF);
      push_err(K_LEN, last_set + 1);
    end
    for (int n = 0; n < 260; n++) begin
      put(SYNC); put(8'(n)); put(8'h00); put(8'(n));
      push_good(8'(n), 0, 64'h0);
    end

    idle(T + 5);
    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
